hilo_mdu: RTL and testbench
===========================

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width and HI/LO register width; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 SHALL have port cancel, input, 1 bit: abort the operation in flight (pipeline flush).
REQ-007 SHALL have ports a and b, input, WIDTH each: a is the multiplicand or dividend; b is the multiplier or divisor.
REQ-008 SHALL have ports hi_we and lo_we, input, 1 bit each: direct write of wdata (MTHI/MTLO).
REQ-009 SHALL have port wdata, input, WIDTH: direct-write data.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port div0, output, 1 bit: high with done when a divide had b==0; low otherwise.
REQ-013 SHALL have ports hi and lo, output, WIDTH each: registered HI/LO contents.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-015 In IDLE, start=1 with cancel=0 SHALL latch a, b and op, and SHALL load the iteration counter with WIDTH.
- The next state is MUL or DIV, chosen by op[1].
REQ-016 start while busy SHALL be ignored.
REQ-017 In IDLE, start=1 together with cancel=1 SHALL start nothing.
REQ-018 Signed operations SHALL iterate on operand magnitudes and SHALL apply sign correction in DONE.
- Product negative iff the operand signs differ.
- Quotient negative iff the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-019 DIV SHALL be a restoring radix-2 divider producing one quotient bit per cycle for WIDTH cycles, then enter DONE.
REQ-020 MUL (iterative build) SHALL be a shift-add multiplier processing one multiplier bit per cycle for WIDTH cycles, then enter DONE.
REQ-021 DONE SHALL last one cycle.
- done=1 in DONE.
- On the edge leaving DONE: HI<=remainder or upper product half; LO<=quotient or lower product half.
- Next state is IDLE.
REQ-022 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH+1 for iterative operations.
- HI/LO are visible after edge k+WIDTH+2.
REQ-023 Divide by zero SHALL take the full divide latency, then set HI=a and LO=all ones and assert div0=1, signed or unsigned.
REQ-024 Signed most-negative / -1 SHALL give LO=most-negative and HI=0, with no flag.
REQ-025 cancel=1 in MUL, DIV or DONE SHALL force IDLE at the next edge with no done, no div0 and HI/LO unchanged.
REQ-026 hi_we/lo_we SHALL write wdata in any state.
- If a direct write coincides with the DONE result write, the result wins.
REQ-027 The full 2*WIDTH product SHALL be kept; no truncation in any intermediate.

Reset
REQ-028 rst low SHALL immediately clear hi, lo, the operand and iteration registers, the counter, busy, done and div0, and SHALL force IDLE.
- This applies even mid-operation.
REQ-029 After rst rises, the block SHALL accept start on the first clock edge.

Configuration
REQ-030 Macro HILO_MDU_FAST_MULT_EN SHALL select the multiplier implementation.
- Defined: MULT/MULTU use a single-cycle combinational signed/unsigned multiplier and skip the MUL state (IDLE->DONE); done is high in the cycle after start edge k.
- Undefined: the iterative MUL path of REQ-020 and REQ-022 is used.
- Divide timing SHALL be identical in both builds.

Verification (WIDTH=32)
REQ-031 DIV a=0xFFFFFFF9, b=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; done 33 cycles after start; div0=0.
REQ-032 DIVU a=0x12345678, b=0 -> HI=0x12345678, LO=0xFFFFFFFF; div0=1 with done.
REQ-033 MULT a=0xFFFFFFFF, b=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Fast build: done 1 cycle after start.
- Iterative build: done 33 cycles after start.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000; div0=0.
REQ-035 Preload HI=0xA, LO=0xB; start DIVU; cancel at cycle 10 -> busy low next cycle; no done; HI=0xA, LO=0xB; new start accepted.
REQ-036 rst low at cycle 5 of DIV -> busy, done, hi and lo all 0 without a clock edge; IDLE after release.

Source files
------------

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: iterative shift-add multiplier and restoring divider.
// Define HILO_MDU_FAST_MULT_EN to replace the iterative multiplier with a one-cycle multiplier.
module hilo_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [WIDTH-1:0] a_mag_q;
  logic [WIDTH-1:0] b_mag_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic             is_div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
`ifndef HILO_MDU_FAST_MULT_EN
  logic [DW-1:0]    acc_q;
  logic [WIDTH:0]   mul_sum_c;
`endif

  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   trial_c;
  logic             qbit_c;
  logic [DW-1:0]    prod_mag_c;
  logic [DW-1:0]    prod_c;
  logic [WIDTH-1:0] quo_s_c;
  logic [WIDTH-1:0] rem_s_c;
  logic             div0_c;
  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;

  // Operand magnitudes, one datapath step, and the sign-corrected result
  always_comb begin
    a_neg_c  = ~op[0] & a[WIDTH-1];
    b_neg_c  = ~op[0] & b[WIDTH-1];
    a_mag_c  = a_neg_c ? (~a + WIDTH'(1)) : a;
    b_mag_c  = b_neg_c ? (~b + WIDTH'(1)) : b;

    rem_sh_c = {rem_q, quo_q[WIDTH-1]};
    trial_c  = rem_sh_c - {1'b0, b_mag_q};
    qbit_c   = ~trial_c[WIDTH];

`ifdef HILO_MDU_FAST_MULT_EN
    prod_mag_c = DW'(a_mag_q) * DW'(b_mag_q);
`else
    mul_sum_c  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : (WIDTH + 1)'(0));
    prod_mag_c = acc_q;
`endif
    prod_c   = (neg_a_q ^ neg_b_q) ? (~prod_mag_c + DW'(1)) : prod_mag_c;
    quo_s_c  = (neg_a_q ^ neg_b_q) ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_s_c  = neg_a_q ? (~rem_q + WIDTH'(1)) : rem_q;
    div0_c   = (b_mag_q == '0);

    if (!is_div_q) begin
      res_hi_c = prod_c[DW-1:WIDTH];
      res_lo_c = prod_c[WIDTH-1:0];
    end else if (div0_c) begin
      res_hi_c = a_raw_q;
      res_lo_c = '1;
    end else begin
      res_hi_c = rem_s_c;
      res_lo_c = quo_s_c;
    end
  end

  // Control FSM, iteration registers and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_raw_q  <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifndef HILO_MDU_FAST_MULT_EN
      acc_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;

      case (state_q)
        S_IDLE: begin
          if (start && !cancel) begin
            a_raw_q  <= a;
            a_mag_q  <= a_mag_c;
            b_mag_q  <= b_mag_c;
            neg_a_q  <= a_neg_c;
            neg_b_q  <= b_neg_c;
            is_div_q <= op[1];
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
            if (op[1]) begin
              state_q <= S_DIV;
              rem_q   <= '0;
              quo_q   <= a_mag_c;
            end else begin
`ifdef HILO_MDU_FAST_MULT_EN
              state_q <= S_DONE;
              done_q  <= 1'b1;
`else
              state_q <= S_MUL;
              acc_q   <= {(WIDTH)'(0), b_mag_c};
`endif
            end
          end
        end

        S_MUL, S_DIV: begin
          if (cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            div0_q  <= is_div_q & div0_c;
          end else begin
            cnt_q <= cnt_q - CW'(1);
            if (state_q == S_DIV) begin
              rem_q <= qbit_c ? trial_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], qbit_c};
            end
`ifndef HILO_MDU_FAST_MULT_EN
            else begin
              acc_q <= {mul_sum_c, acc_q[WIDTH-1:1]};
            end
`endif
          end
        end

        // Result write is placed after the direct writes so it takes priority
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!cancel) begin
            hi_q <= res_hi_c;
            lo_q <= res_lo_c;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: latency/arithmetic model, directed cases and random traffic.
module tb_hilo_mdu;

  localparam int unsigned W = 32;
`ifdef HILO_MDU_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          cancel = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy;
  logic          done;
  logic          div0;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int total = 0;
  int bad   = 0;

  hilo_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: what HI/LO must hold after an operation
  function automatic void calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [W-1:0] rh, output logic [W-1:0] rl, output logic dz);
    longint sx, sy, p;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin up = 64'(x) * 64'(y); rh = up[63:32]; rl = up[31:0]; end
      2'b10: begin
        if (y == 0) begin rh = x; rl = '1; dz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = '0; end
        else begin p = sx / sy; rl = p[31:0]; p = sx % sy; rh = p[31:0]; end
      end
      default: begin
        if (y == 0) begin rh = x; rl = '1; dz = 1'b1; end
        else begin rl = x / y; rh = x % y; end
      end
    endcase
  endfunction

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic         r_dz;
    logic [7:0]   wt;
  } mdl_t;

  mdl_t m;

  // Model: an accepted op completes after a fixed number of edges unless cancelled
  function automatic mdl_t step(input mdl_t s);
    mdl_t n;
    n = s;
    n.done = 1'b0;
    n.div0 = 1'b0;
    if (hi_we) n.hi = wdata;
    if (lo_we) n.lo = wdata;
    if (!s.busy) begin
      if (start && !cancel) begin
        calc(op, a, b, n.r_hi, n.r_lo, n.r_dz);
        n.busy = 1'b1;
        if (!op[1] && FAST) begin
          n.done = 1'b1;
          n.wt   = 8'd0;
        end else begin
          n.wt = 8'(W + 1);
        end
      end
    end else if (s.done) begin
      n.busy = 1'b0;
      if (!cancel) begin
        n.hi = s.r_hi;
        n.lo = s.r_lo;
      end
    end else if (cancel) begin
      n.busy = 1'b0;
    end else begin
      n.wt = s.wt - 8'd1;
      if (n.wt == 8'd0) begin
        n.done = 1'b1;
        n.div0 = s.r_dz;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= step(m);
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m.busy));
    chk("done", 64'(done), 64'(m.done));
    chk("div0", 64'(div0), 64'(m.div0));
    chk("hi",   64'(hi),   64'(m.hi));
    chk("lo",   64'(lo),   64'(m.lo));
  end

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  // lat = edges after the start edge until done is seen
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic dz, output logic [W-1:0] rh,
                       output logic [W-1:0] rl);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 64'(done), 64'd1);
    dz = div0;
    @(negedge clk);
    rh = hi;
    rl = lo;
  endtask

  initial begin
    int lat;
    logic dz;
    logic [W-1:0] rh, rl;
    logic saw_done;
    int unsigned exp_mul_lat;

    exp_mul_lat = FAST ? 0 : W + 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    #2 rst = 1'b1;

    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, dz, rh, rl);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_div0", 64'(dz), 64'd0);
    chk("div_lo", 64'(rl), 64'hFFFF_FFFD);
    chk("div_hi", 64'(rh), 64'hFFFF_FFFF);

    do_op(2'b11, 32'h1234_5678, 32'h0, lat, dz, rh, rl);
    chk("divu0_lat", 64'(lat), 64'd33);
    chk("divu0_div0", 64'(dz), 64'd1);
    chk("divu0_hi", 64'(rh), 64'h1234_5678);
    chk("divu0_lo", 64'(rl), 64'hFFFF_FFFF);

    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, lat, dz, rh, rl);
    chk("mult_lat", 64'(lat), 64'(exp_mul_lat));
    chk("mult_hi", 64'(rh), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(rl), 64'hFFFF_FFFE);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, dz, rh, rl);
    chk("minneg_div0", 64'(dz), 64'd0);
    chk("minneg_lo", 64'(rl), 64'h8000_0000);
    chk("minneg_hi", 64'(rh), 64'h0);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, dz, rh, rl);
    chk("multu_hi", 64'(rh), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(rl), 64'h0000_0001);

    // Cancel mid-divide leaves preloaded HI/LO untouched
    @(negedge clk); hi_we = 1'b1; wdata = 32'hA;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hB;
    @(negedge clk); lo_we = 1'b0; start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    saw_done = 1'b0;
    repeat (9) begin @(negedge clk); saw_done |= done; end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    repeat (3) begin @(negedge clk); saw_done |= done; end
    chk("cancel_nodone", 64'(saw_done), 64'd0);
    chk("cancel_hi", 64'(hi), 64'hA);
    chk("cancel_lo", 64'(lo), 64'hB);
    do_op(2'b11, 32'd100, 32'd7, lat, dz, rh, rl);
    chk("after_cancel_hi", 64'(rh), 64'd2);
    chk("after_cancel_lo", 64'(rl), 64'd14);

    // Asynchronous reset in the middle of a divide
    @(negedge clk); start = 1'b1; op = 2'b10; a = 32'hFFFF_FF9C; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi",   64'(hi),   64'd0);
    chk("arst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    #2 rst = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(negedge clk); start = 1'b0;
    chk("first_edge_start", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("post_rst_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("post_rst_lo", 64'(lo), 64'd15);
    chk("post_rst_hi", 64'(hi), 64'd0);

    // Random traffic: starts while busy, cancels, direct writes racing results
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start  = ($urandom % 4) == 0;
      op     = 2'($urandom);
      a      = pick();
      b      = pick();
      cancel = ($urandom % 64) == 0;
      hi_we  = ($urandom % 16) == 0;
      lo_we  = ($urandom % 16) == 0;
      wdata  = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
